fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/fetch_stage.sv | 152 +++++++++++++++
 tb/tb_fetch_stage.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Brief    : Shared CPU constants and fetch-stage state encoding
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

   localparam int          XLEN = 32;
   // addi x0, x0, 0 -- canonical RISC-V no-op used for pipeline bubbles
   localparam logic [31:0] NOP  = 32'h0000_0013;

   // FETCH: request outstanding; HOLD: response parked in skid buffer;
   // DROP: outstanding response belongs to a squashed path and is discarded
   typedef enum logic [1:0] {
      FETCH = 2'd0,
      HOLD  = 2'd1,
      DROP  = 2'd2
   } fetch_state_e;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Brief    : Instruction fetch with IF/ID register, one-entry skid buffer
//             and redirect handling for in-flight memory requests
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
   import cpu_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            stall_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] target_i,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_ack_i,
   input  logic [XLEN-1:0] imem_rdata_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] instr_o,
   output logic            valid_o
);

   // Word alignment mask applied to redirect targets
   localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

   fetch_state_e    state, state_next;
   logic [XLEN-1:0] pc, pc_next;              // address of next fetch
   logic [XLEN-1:0] drop_addr, drop_addr_next; // address of squashed request
   logic [XLEN-1:0] skid_instr, skid_next;
   logic [XLEN-1:0] if_pc, if_pc_next;
   logic [XLEN-1:0] if_instr, if_instr_next;
   logic            if_valid, if_valid_next;
   logic [XLEN-1:0] target_aligned;

   assign target_aligned = target_i & ALIGN_MASK;

   // Request is suppressed during reset; a squashed request keeps its
   // original address on the bus until its response returns.
   assign imem_req_o  = !rst_i && (state != HOLD);
   assign imem_addr_o = (state == DROP) ? drop_addr : pc;

   assign pc_o    = if_pc;
   assign instr_o = if_instr;
   assign valid_o = if_valid;

   // State register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= FETCH;
      end else begin
         state <= state_next;
      end
   end

   // Datapath registers: PC, squashed address, skid buffer and IF/ID
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pc         <= RESET_PC;
         drop_addr  <= RESET_PC;
         skid_instr <= NOP;
         if_pc      <= '0;
         if_instr   <= NOP;
         if_valid   <= 1'b0;
      end else begin
         pc         <= pc_next;
         drop_addr  <= drop_addr_next;
         skid_instr <= skid_next;
         if_pc      <= if_pc_next;
         if_instr   <= if_instr_next;
         if_valid   <= if_valid_next;
      end
   end

   // Next-state and datapath update; flush outranks ack and stall everywhere
   always_comb begin
      state_next     = state;
      pc_next        = pc;
      drop_addr_next = drop_addr;
      skid_next      = skid_instr;
      if_pc_next     = if_pc;
      if_instr_next  = if_instr;
      if_valid_next  = if_valid;

      case (state)
         FETCH: begin
            if (flush_i) begin
               if_instr_next = NOP;
               if_valid_next = 1'b0;
               pc_next       = target_aligned;
               if (!imem_ack_i) begin
                  // Response still owed for the old address: remember it
                  state_next     = DROP;
                  drop_addr_next = pc;
               end
            end else if (imem_ack_i) begin
               if (stall_i) begin
                  skid_next  = imem_rdata_i;
                  state_next = HOLD;
               end else begin
                  if_pc_next    = pc;
                  if_instr_next = imem_rdata_i;
                  if_valid_next = 1'b1;
                  pc_next       = pc + 32'd4;
               end
            end else if (!stall_i) begin
               if_instr_next = NOP;
               if_valid_next = 1'b0;
            end
         end

         HOLD: begin
            if (flush_i) begin
               if_instr_next = NOP;
               if_valid_next = 1'b0;
               pc_next       = target_aligned;
               state_next    = FETCH;
            end else if (!stall_i) begin
               if_pc_next    = pc;
               if_instr_next = skid_instr;
               if_valid_next = 1'b1;
               pc_next       = pc + 32'd4;
               state_next    = FETCH;
            end
         end

         DROP: begin
            if (flush_i) begin
               // Latest redirect wins; the bus address stays on the old request
               if_instr_next = NOP;
               if_valid_next = 1'b0;
               pc_next       = target_aligned;
            end else if (!stall_i) begin
               if_instr_next = NOP;
               if_valid_next = 1'b0;
            end
            if (imem_ack_i) begin
               state_next = FETCH;
            end
         end

         default: begin
            state_next = FETCH;
         end
      endcase
   end

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Brief    : Directed self-checking bench for fetch_stage
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

   localparam logic [31:0] NOP_I = 32'h0000_0013;

   logic        clk;
   logic        rst;
   logic        stall;
   logic        flush;
   logic [31:0] target;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        valid;

   int checks = 0;
   int errors = 0;

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .stall_i      (stall),
      .flush_i      (flush),
      .target_i     (target),
      .imem_req_o   (imem_req),
      .imem_addr_o  (imem_addr),
      .imem_ack_i   (imem_ack),
      .imem_rdata_i (imem_rdata),
      .pc_o         (pc),
      .instr_o      (instr),
      .valid_o      (valid)
   );

   // 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; memory returns addr ^ 32'h1300_0000 for whatever
   // address is on the bus after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
      imem_rdata = imem_addr ^ 32'h1300_0000;
      #1;
   endtask

   task automatic chk_ifid(input string tag, input logic [31:0] epc,
                           input logic [31:0] einstr, input logic evalid);
      chk({tag, "_pc"}, pc, epc);
      chk({tag, "_instr"}, instr, einstr);
      chk({tag, "_valid"}, {31'd0, valid}, {31'd0, evalid});
   endtask

   initial begin
      rst        = 1'b1;
      stall      = 1'b0;
      flush      = 1'b0;
      target     = 32'h0;
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEAD_BEEF;

      // Reset, with acks arriving that must be ignored
      tick();
      tick();
      chk("rst_req", {31'd0, imem_req}, 32'd0);
      chk_ifid("rst", 32'h0, NOP_I, 1'b0);
      rst = 1'b0;
      #1;
      chk("post_rst_req", {31'd0, imem_req}, 32'd1);
      chk("post_rst_addr", imem_addr, 32'h0);

      // Zero-wait streaming
      tick(); chk_ifid("zw0", 32'h0, 32'h1300_0000, 1'b1);
      chk("zw0_addr", imem_addr, 32'h4);
      tick(); chk_ifid("zw1", 32'h4, 32'h1300_0004, 1'b1);
      tick(); chk_ifid("zw2", 32'h8, 32'h1300_0008, 1'b1);
      tick(); chk_ifid("zw3", 32'hC, 32'h1300_000C, 1'b1);
      chk("zw3_addr", imem_addr, 32'h10);

      // Flush (unaligned target) while request to 0x10 is pending
      imem_ack = 1'b0; flush = 1'b1; target = 32'h0000_0101;
      tick(); chk_ifid("fl_drop", 32'hC, NOP_I, 1'b0);
      chk("fl_drop_addr", imem_addr, 32'h10);
      chk("fl_drop_req", {31'd0, imem_req}, 32'd1);
      flush = 1'b0;
      tick(); chk("drop_wait_addr", imem_addr, 32'h10);
      imem_ack = 1'b1;
      tick(); chk("drop_ack_valid", {31'd0, valid}, 32'd0);
      chk("drop_ack_addr", imem_addr, 32'h100);
      tick(); chk_ifid("redir", 32'h100, 32'h1300_0100, 1'b1);
      chk("redir_addr", imem_addr, 32'h104);

      // Wait states: bubbles while the address holds
      imem_ack = 1'b0;
      tick(); chk_ifid("ws0", 32'h100, NOP_I, 1'b0);
      chk("ws0_addr", imem_addr, 32'h104);
      tick(); chk("ws1_addr", imem_addr, 32'h104);
      chk("ws1_valid", {31'd0, valid}, 32'd0);
      imem_ack = 1'b1;
      tick(); chk_ifid("ws_done", 32'h104, 32'h1300_0104, 1'b1);
      chk("ws_done_addr", imem_addr, 32'h108);

      // Ack under stall: skid buffer, request dropped, IF/ID frozen
      stall = 1'b1;
      tick(); chk_ifid("hold0", 32'h104, 32'h1300_0104, 1'b1);
      chk("hold0_req", {31'd0, imem_req}, 32'd0);
      imem_ack = 1'b0;
      tick(); chk_ifid("hold1", 32'h104, 32'h1300_0104, 1'b1);
      chk("hold1_req", {31'd0, imem_req}, 32'd0);
      stall = 1'b0;
      tick(); chk_ifid("unhold", 32'h108, 32'h1300_0108, 1'b1);
      chk("unhold_req", {31'd0, imem_req}, 32'd1);
      chk("unhold_addr", imem_addr, 32'h10C);
      imem_ack = 1'b1;
      tick(); chk_ifid("after_hold", 32'h10C, 32'h1300_010C, 1'b1);

      // Flush + stall + ack together
      stall = 1'b1; flush = 1'b1; target = 32'h200;
      tick(); chk_ifid("fsa", 32'h10C, NOP_I, 1'b0);
      chk("fsa_addr", imem_addr, 32'h200);
      stall = 1'b0; flush = 1'b0;
      tick(); chk_ifid("fsa_next", 32'h200, 32'h1300_0200, 1'b1);

      // Flush while in HOLD discards the buffered word
      stall = 1'b1;
      tick(); chk("hold_f_req", {31'd0, imem_req}, 32'd0);
      flush = 1'b1; target = 32'h300;
      tick(); chk("hold_f_valid", {31'd0, valid}, 32'd0);
      chk("hold_f_addr", imem_addr, 32'h300);
      flush = 1'b0; stall = 1'b0;
      tick(); chk_ifid("hold_f_next", 32'h300, 32'h1300_0300, 1'b1);

      // Repeated flush in DROP: latest target wins
      imem_ack = 1'b0; flush = 1'b1; target = 32'h400;
      tick(); chk("rf0_addr", imem_addr, 32'h304);
      target = 32'h500;
      tick(); chk("rf1_addr", imem_addr, 32'h304);
      flush = 1'b0; imem_ack = 1'b1;
      tick(); chk("rf_done_addr", imem_addr, 32'h500);
      chk("rf_done_valid", {31'd0, valid}, 32'd0);
      tick(); chk_ifid("rf_next", 32'h500, 32'h1300_0500, 1'b1);

      // PC wrap
      flush = 1'b1; target = 32'hFFFF_FFFC;
      tick(); chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
      flush = 1'b0;
      tick(); chk_ifid("wrap", 32'hFFFF_FFFC, 32'hECFF_FFFC, 1'b1);
      chk("wrap_addr1", imem_addr, 32'h0);

      // Reset mid-operation with an ack present
      rst = 1'b1;
      #1;
      chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
      tick(); chk_ifid("mid_rst", 32'h0, NOP_I, 1'b0);
      rst = 1'b0;
      #1;
      chk("mid_rst_addr", imem_addr, 32'h0);
      chk("mid_rst_req1", {31'd0, imem_req}, 32'd1);
      tick(); chk_ifid("mid_rst_next", 32'h0, 32'h1300_0000, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_fetch_stage
`default_nettype wire
